// File: rtl/ifft8_seq_if.sv
// Streaming handshake bundle for the 8-point IFFT: sample-in channel, sample-out channel, busy flag.
interface ifft8_seq_if;
  logic              in_valid;
  logic signed [7:0] in_re;
  logic signed [7:0] in_im;
  logic              in_ready;
  logic              out_valid;
  logic signed [7:0] out_re;
  logic signed [7:0] out_im;
  logic              out_ready;
  logic              busy;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, busy
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, busy
  );
endinterface

// File: rtl/ifft8_seq.sv
// Sequential 8-point radix-2 DIT inverse FFT: load 8 samples bit-reversed, run one
// in-place butterfly per cycle for 12 cycles, then stream x[n]/8 out with saturation.
module ifft8_seq (
  input  logic       clk,
  input  logic       rst_n,
  ifft8_seq_if.slave io
);
  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic signed [7:0]  out_re_q, out_re_d, out_im_q, out_im_d;

  logic signed [11:0] buf_re_q [8];
  logic signed [11:0] buf_im_q [8];
  logic signed [11:0] buf_re_d [8];
  logic signed [11:0] buf_im_d [8];

  logic [2:0]         ld_idx, ia, ib;
  logic [1:0]         tw_k;
  logic signed [7:0]  tw_c, tw_s;
  logic signed [11:0] a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [20:0] prod_re, prod_im;

  // Butterfly schedule: {a index, b index, twiddle index} for step 0..11.
  function automatic logic [7:0] bf_map(input logic [3:0] step);
    case (step)
      4'd0:    return {3'd0, 3'd1, 2'd0};
      4'd1:    return {3'd2, 3'd3, 2'd0};
      4'd2:    return {3'd4, 3'd5, 2'd0};
      4'd3:    return {3'd6, 3'd7, 2'd0};
      4'd4:    return {3'd0, 3'd2, 2'd0};
      4'd5:    return {3'd1, 3'd3, 2'd2};
      4'd6:    return {3'd4, 3'd6, 2'd0};
      4'd7:    return {3'd5, 3'd7, 2'd2};
      4'd8:    return {3'd0, 3'd4, 2'd0};
      4'd9:    return {3'd1, 3'd5, 2'd1};
      4'd10:   return {3'd2, 3'd6, 2'd2};
      4'd11:   return {3'd3, 3'd7, 2'd3};
      default: return {3'd0, 3'd1, 2'd0};
    endcase
  endfunction

  function automatic logic signed [7:0] tw_cos(input logic [1:0] k);
    case (k)
      2'd0:    return 8'sd64;
      2'd1:    return 8'sd45;
      2'd2:    return 8'sd0;
      default: return -8'sd45;
    endcase
  endfunction

  function automatic logic signed [7:0] tw_sin(input logic [1:0] k);
    case (k)
      2'd0:    return 8'sd0;
      2'd2:    return 8'sd64;
      default: return 8'sd45;
    endcase
  endfunction

  // Divide by 8 with floor, then clamp into the 8-bit output range.
  function automatic logic signed [7:0] scale_sat(input logic signed [11:0] v);
    logic signed [8:0] s;
    s = $signed(v[11:3]);
    if (s > 9'sd127)       return 8'sd127;
    else if (s < -9'sd128) return -8'sd128;
    else                   return s[7:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_re_d = buf_re_q;
    buf_im_d = buf_im_q;

    ld_idx = {cnt_q[0], cnt_q[1], cnt_q[2]};
    {ia, ib, tw_k} = bf_map(cnt_q);
    tw_c = tw_cos(tw_k);
    tw_s = tw_sin(tw_k);
    a_re = buf_re_q[ia];
    a_im = buf_im_q[ia];
    b_re = buf_re_q[ib];
    b_im = buf_im_q[ib];
    prod_re = 21'(b_re) * 21'(tw_c) - 21'(b_im) * 21'(tw_s);
    prod_im = 21'(b_re) * 21'(tw_s) + 21'(b_im) * 21'(tw_c);
    t_re = prod_re[17:6];
    t_im = prod_im[17:6];

    case (state_q)
      LOAD: begin
        if (io.in_valid) begin
          buf_re_d[ld_idx] = {{4{io.in_re[7]}}, io.in_re};
          buf_im_d[ld_idx] = {{4{io.in_im[7]}}, io.in_im};
          if (cnt_q == 4'd7) begin
            state_d = COMPUTE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      COMPUTE: begin
        buf_re_d[ia] = a_re + t_re;
        buf_im_d[ia] = a_im + t_im;
        buf_re_d[ib] = a_re - t_re;
        buf_im_d[ib] = a_im - t_im;
        if (cnt_q == 4'd11) begin
          state_d = OUTPUT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      OUTPUT: begin
        if (io.out_ready) begin
          if (cnt_q == 4'd7) begin
            state_d = LOAD;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = 4'd0;
      end
    endcase

    // Outputs are registered from the next-state view so they line up with state_q.
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == OUTPUT);
    busy_d      = (state_d != LOAD);
    out_re_d    = out_valid_d ? scale_sat(buf_re_d[cnt_d[2:0]]) : 8'sd0;
    out_im_d    = out_valid_d ? scale_sat(buf_im_d[cnt_d[2:0]]) : 8'sd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_re_q    <= 8'sd0;
      out_im_q    <= 8'sd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      buf_re_q[i] <= buf_re_d[i];
      buf_im_q[i] <= buf_im_d[i];
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = busy_q;
  assign io.out_re    = out_re_q;
  assign io.out_im    = out_im_q;
endmodule

// File: tb/tb_ifft8_seq.sv
// Directed bench for ifft8_seq: frames are scored against a loop-based fixed-point IFFT model.
module tb_ifft8_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifft8_seq_if io();
  ifft8_seq dut (.clk(clk), .rst_n(rst_n), .io(io.slave));

  int checks = 0;
  int errors = 0;
  int q_re[$];
  int q_im[$];
  int fr_re[8];
  int fr_im[8];
  int m_re[8];
  int m_im[8];
  int rdy_mode = 0;
  int rdy_phase = 0;
  int out_idx = 0;
  bit done_pending = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Generic DIT IFFT: bit-reversed load, spans 1/2/4, twiddle k = j*4/span, floor shifts.
  task automatic model();
    int br[8];
    int bi[8];
    int tc[4];
    int ts[4];
    tc = '{64, 45, 0, -45};
    ts = '{0, 45, 64, 45};
    for (int i = 0; i < 8; i++) begin
      int rv;
      rv = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
      br[rv] = fr_re[i];
      bi[rv] = fr_im[i];
    end
    for (int span = 1; span < 8; span = span * 2)
      for (int g = 0; g < 8; g = g + 2 * span)
        for (int j = 0; j < span; j++) begin
          int a, b, k, tr, ti, ar, ai;
          a = g + j;
          b = a + span;
          k = j * 4 / span;
          tr = (br[b] * tc[k] - bi[b] * ts[k]) >>> 6;
          ti = (br[b] * ts[k] + bi[b] * tc[k]) >>> 6;
          ar = br[a];
          ai = bi[a];
          br[a] = ar + tr;
          bi[a] = ai + ti;
          br[b] = ar - tr;
          bi[b] = ai - ti;
        end
    for (int n = 0; n < 8; n++) begin
      int vr, vi;
      vr = br[n] >>> 3;
      vi = bi[n] >>> 3;
      m_re[n] = (vr > 127) ? 127 : (vr < -128) ? -128 : vr;
      m_im[n] = (vi > 127) ? 127 : (vi < -128) ? -128 : vi;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) io.out_ready = 1'b1;
    else begin
      io.out_ready = (rdy_phase % 3 == 0);
      rdy_phase++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (io.in_ready && io.out_valid) chk("ready_valid_exclusive", 1, 0);
      if (io.busy) chk("in_ready_while_busy", int'(io.in_ready), 0);
      if (done_pending) begin
        chk("in_ready_after_frame", int'(io.in_ready), 1);
        done_pending = 0;
      end
      if (io.out_valid) begin
        if (q_re.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          chk($sformatf("x%0d_re", out_idx), int'(io.out_re), q_re[0]);
          chk($sformatf("x%0d_im", out_idx), int'(io.out_im), q_im[0]);
          if (io.out_ready) begin
            void'(q_re.pop_front());
            void'(q_im.pop_front());
            out_idx = (out_idx + 1) % 8;
            if (out_idx == 0) done_pending = 1;
          end
        end
      end
    end
  end

  task automatic send_frame(input bit push, input bit gapped, input int count);
    int i, cyc;
    bit acc;
    model();
    if (push)
      for (int n = 0; n < 8; n++) begin
        q_re.push_back(m_re[n]);
        q_im.push_back(m_im[n]);
      end
    i = 0;
    cyc = 0;
    while (i < count && cyc < 100) begin
      io.in_valid = gapped ? ((cyc % 5 != 1) && (cyc % 5 != 4)) : 1'b1;
      io.in_re = 8'(fr_re[i]);
      io.in_im = 8'(fr_im[i]);
      acc = io.in_valid && io.in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      cyc++;
    end
    io.in_valid = 1'b0;
    if (i < count) chk("load_timeout", i, count);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q_re.size() != 0 || io.busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    io.in_valid = 1'b0;
    chk("frame_drain", int'(n < 300), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, int'(io.out_valid), 0);
    chk({tag, "_in_ready"}, int'(io.in_ready), 1);
    chk({tag, "_busy"}, int'(io.busy), 0);
    chk({tag, "_out_re"}, int'(io.out_re), 0);
    chk({tag, "_out_im"}, int'(io.out_im), 0);
  endtask

  initial begin
    int n;
    io.in_valid = 1'b0;
    io.in_re = 8'sd0;
    io.in_im = 8'sd0;
    io.out_ready = 1'b1;
    #12;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Impulse with latency measurement
    fr_re = '{64, 0, 0, 0, 0, 0, 0, 0};
    fr_im = '{default: 0};
    send_frame(1, 0, 8);
    chk("model_imp_x0_re", m_re[0], 8);
    chk("model_imp_x5_re", m_re[5], 8);
    chk("model_imp_x5_im", m_im[5], 0);
    n = 0;
    while (!io.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("first_out_latency", n, 12);
    wait_done();

    // DC
    fr_re = '{80, 80, 80, 80, 80, 80, 80, 80};
    fr_im = '{default: 0};
    send_frame(1, 0, 8);
    chk("model_dc_x0_re", m_re[0], 80);
    chk("model_dc_x3_re", m_re[3], 0);
    wait_done();

    // Nyquist
    fr_re = '{0, 0, 0, 0, 64, 0, 0, 0};
    fr_im = '{default: 0};
    send_frame(1, 0, 8);
    chk("model_nyq_x1_re", m_re[1], -8);
    chk("model_nyq_x2_re", m_re[2], 8);
    wait_done();

    // Quarter-rate imaginary bin
    fr_re = '{default: 0};
    fr_im = '{0, 0, 64, 0, 0, 0, 0, 0};
    send_frame(1, 0, 8);
    chk("model_x2_x0_im", m_im[0], 8);
    chk("model_x2_x1_re", m_re[1], -8);
    chk("model_x2_x2_im", m_im[2], -8);
    chk("model_x2_x3_re", m_re[3], 8);
    wait_done();

    // Backpressure on an impulse frame
    rdy_mode = 1;
    rdy_phase = 0;
    fr_re = '{64, 0, 0, 0, 0, 0, 0, 0};
    fr_im = '{default: 0};
    send_frame(1, 0, 8);
    wait_done();
    rdy_mode = 0;

    // Gapped load, in_valid held with junk during COMPUTE/OUTPUT
    fr_re = '{10, 33, -50, 5, -128, 90, 0, 127};
    fr_im = '{-20, 7, 12, 5, 127, -3, -77, -128};
    send_frame(1, 1, 8);
    io.in_valid = 1'b1;
    io.in_re = 8'sd99;
    io.in_im = -8'sd99;
    wait_done();

    // Output saturation: every term of x[1] aligned to the real axis
    fr_re = '{127, 127, 0, -127, -127, -127, 0, 127};
    fr_im = '{0, -127, -127, -127, 0, 127, 127, 127};
    send_frame(1, 0, 8);
    chk("model_sat_x1_re", m_re[1], 127);
    wait_done();

    // Reset mid-LOAD, then a Nyquist frame
    fr_re = '{80, 80, 80, 80, 80, 80, 80, 80};
    fr_im = '{default: 0};
    send_frame(0, 0, 3);
    rst_n = 1'b0;
    #1;
    reset_checks("rst_load");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fr_re = '{0, 0, 0, 0, 64, 0, 0, 0};
    fr_im = '{default: 0};
    send_frame(1, 0, 8);
    wait_done();

    // Reset after 5 butterflies, then a DC frame
    fr_re = '{64, 0, 0, 0, 0, 0, 0, 0};
    fr_im = '{default: 0};
    send_frame(0, 0, 8);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    reset_checks("rst_compute");
    @(posedge clk);
    #1;
    chk("rst_compute_hold_out_valid", int'(io.out_valid), 0);
    #1;
    rst_n = 1'b1;
    q_re.delete();
    q_im.delete();
    out_idx = 0;
    @(posedge clk);
    #1;
    fr_re = '{80, 80, 80, 80, 80, 80, 80, 80};
    fr_im = '{default: 0};
    send_frame(1, 0, 8);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifft8_seq.md
IFFT8_SEQ -- requirements
Module: ifft8_seq

Interface
REQ-001 The block SHALL take no parameters; all widths and constants are fixed as below.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  source presents one frequency-domain sample.
REQ-006 in_re, in_im  input  8 each  signed two's-complement X[k]; samples arrive in order k=0..7.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 out_valid  output  1  time-domain sample presented.
REQ-009 out_re, out_im  output  8 each  signed x[n]; samples leave in order n=0..7.
REQ-010 out_ready  input  1  sink accepts the presented sample.
REQ-011 busy  output  1  high in COMPUTE and OUTPUT.

Function
REQ-012 The block SHALL use a three-state FSM with states LOAD, COMPUTE and OUTPUT.
REQ-013 LOAD: in_ready=1; each cycle with in_valid&in_ready stores one sample sign-extended to 12 bits at the bit-reversed index of a 3-bit load counter.
  - Bit-reversed index map: 0,4,2,6,1,5,3,7.
REQ-014 The edge that accepts the 8th sample SHALL move the FSM to COMPUTE and clear the counter.
REQ-015 COMPUTE: in_ready=0; in_valid is ignored; exactly one radix-2 DIT butterfly SHALL execute per cycle, for 12 cycles.
  - Stage 1: span 1, pairs (0,1)(2,3)(4,5)(6,7), twiddle index 0.
  - Stage 2: span 2, pairs (0,2)(1,3)(4,6)(5,7), twiddle indices 0,2,0,2.
  - Stage 3: span 4, pairs (0,4)(1,5)(2,6)(3,7), twiddle indices 0,1,2,3.
REQ-016 Butterfly: t=W*b; a'=a+t; b'=a-t; both results are written back in place on the same edge.
REQ-017 Inverse twiddles W^k (re,im) scaled by 64 SHALL be: k0 (64,0); k1 (45,45); k2 (0,64); k3 (-45,45).
REQ-018 Complex multiply: t.re=(b.re*c-b.im*d)>>>6 and t.im=(b.re*d+b.im*c)>>>6.
  - Operands are full-precision signed.
  - >>> is an arithmetic (floor) shift.
  - k0 SHALL yield t=b exactly.
REQ-019 Internal arithmetic SHALL be 12-bit signed; no overflow can occur for any 8-bit input, so there is no internal saturation.
REQ-020 After the 12th butterfly edge, the FSM SHALL enter OUTPUT. First out_valid is high 12 edges after the edge that accepted the 8th input.
REQ-021 OUTPUT: out_valid=1; out_re/out_im SHALL be buffer[n]>>>3 (1/N scaling, floor), saturated to [-128,127], for n=output counter.
REQ-022 Each cycle with out_valid&out_ready SHALL advance n.
  - While out_ready=0, outputs and n SHALL hold stable.
REQ-023 The edge that transfers n=7 SHALL return the FSM to LOAD, with in_ready high on the next cycle. There are no bubbles other than that edge.
REQ-024 in_ready and out_valid SHALL never be high in the same cycle.
REQ-025 Outputs SHALL be registered or derived from registered state only; no combinational path from in_valid or out_ready to any output.

Reset
REQ-026 While rst_n=0, the block SHALL be in LOAD with counters at 0, in_ready=1, out_valid=0, busy=0, and out_re=out_im=0.
REQ-027 Reset asserted mid-LOAD, mid-COMPUTE or mid-OUTPUT SHALL discard the partial frame immediately (asynchronously).
  - The first post-reset accepted sample is X[0] of a new frame.
REQ-028 Sample buffer contents need not be reset.

Verification
REQ-029 Impulse: X[0]=(64,0), X[1..7]=(0,0), out_ready=1 -> x[0..7] all (8,0); first out_valid exactly 12 edges after 8th accept.
REQ-030 DC: all X[k]=(80,0) -> x[0]=(80,0), x[1..7]=(0,0).
REQ-031 Nyquist: X[4]=(64,0), others 0 -> x[n]=(8,0) for even n and (-8,0) for odd n. Also X[2]=(0,64), others 0 -> x=(0,8),(-8,0),(0,-8),(8,0), repeated.
REQ-032 Backpressure: impulse frame with out_ready toggled 1,0,0,1,... -> each x[n] held stable while out_ready=0; exactly 8 transfers; in_ready low until the 8th transfer edge.
REQ-033 Flow: in_valid held high during COMPUTE and OUTPUT -> no samples consumed; in_ready=0 throughout. A gapped in_valid pattern (1,0,1,1,0,...) during LOAD -> same result as gapless.
REQ-034 Reset mid-COMPUTE (after 5 butterflies) then a full DC frame -> outputs match REQ-030; out_valid=0 during reset.
